// File: rtl/ram_array.sv
// Word-addressable register-array memory: port A read/write, port B read-only.
// Async reset, single-cycle bulk clear, optional write-through bypass on reads.
module ram_array #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address_b,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem       [DEPTH];
  logic [WIDTH-1:0] next_word [DEPTH];
  logic             write_active;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Clear wins over load; reset also suppresses any pending write.
  assign write_active = load & ~clear & ~rst;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_comb begin
      next_word[g] = mem[g];
      if (clear) begin
        next_word[g] = '0;
      end else if (load && (address == ADDR_W'(g))) begin
        next_word[g] = in;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem[g] <= '0;
      end else begin
        mem[g] <= next_word[g];
      end
    end
  end

  assign rd_a = mem[address];
  assign rd_b = mem[address_b];

  // With bypass, a word being written is visible on the read ports in the same cycle.
  always_comb begin
    out   = rd_a;
    out_b = rd_b;
    if (BYPASS != 0 && write_active) begin
      out = in;
      if (address_b == address) begin
        out_b = in;
      end
    end
  end

endmodule

// File: tb/tb_ram_array.sv
// Directed bench for ram_array: default config, bypass config and a wide-address config.
module tb_ram_array;

  logic clk = 1'b0;
  logic rst;

  logic        a_load, a_clear;
  logic [2:0]  a_addr, a_addr_b;
  logic [15:0] a_in, a_out, a_out_b;

  logic        b_load, b_clear;
  logic [2:0]  b_addr, b_addr_b;
  logic [15:0] b_in, b_out, b_out_b;

  logic        c_load, c_clear;
  logic [4:0]  c_addr, c_addr_b;
  logic [7:0]  c_in, c_out, c_out_b;

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  ram_array u_a (
    .clk(clk), .rst(rst), .load(a_load), .clear(a_clear), .address(a_addr),
    .in(a_in), .address_b(a_addr_b), .out(a_out), .out_b(a_out_b)
  );

  ram_array #(.WIDTH(16), .ADDR_W(3), .BYPASS(1)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .clear(b_clear), .address(b_addr),
    .in(b_in), .address_b(b_addr_b), .out(b_out), .out_b(b_out_b)
  );

  ram_array #(.WIDTH(8), .ADDR_W(5), .BYPASS(0)) u_c (
    .clk(clk), .rst(rst), .load(c_load), .clear(c_clear), .address(c_addr),
    .in(c_in), .address_b(c_addr_b), .out(c_out), .out_b(c_out_b)
  );

  // scoreboard
  task automatic expect_val(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // drivers
  task automatic a_write(input logic [2:0] ad, input logic [15:0] d);
    @(negedge clk);
    a_load = 1'b1; a_addr = ad; a_in = d;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic a_read(input logic [2:0] ad, input logic [2:0] ad_b);
    @(negedge clk);
    a_addr = ad; a_addr_b = ad_b;
    #1;
  endtask

  task automatic b_write(input logic [2:0] ad, input logic [15:0] d);
    @(negedge clk);
    b_load = 1'b1; b_addr = ad; b_in = d;
    @(posedge clk); #1;
    b_load = 1'b0;
  endtask

  task automatic c_write(input logic [4:0] ad, input logic [7:0] d);
    @(negedge clk);
    c_load = 1'b1; c_addr = ad; c_in = d;
    @(posedge clk); #1;
    c_load = 1'b0;
  endtask

  task automatic c_read(input logic [4:0] ad, input logic [4:0] ad_b);
    @(negedge clk);
    c_addr = ad; c_addr_b = ad_b;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_load = 0; a_clear = 0; a_addr = 0; a_addr_b = 0; a_in = 0;
    b_load = 0; b_clear = 0; b_addr = 0; b_addr_b = 0; b_in = 0;
    c_load = 0; c_clear = 0; c_addr = 0; c_addr_b = 0; c_in = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_val(16'h0000); check("reset_out", a_out);
    expect_val(16'h0000); check("reset_out_b", a_out_b);
    @(negedge clk);
    rst = 1'b0;

    // Reset: fill with ones, pulse rst between edges.
    for (int k = 0; k < 8; k++) a_write(3'(k), 16'hFFFF);
    a_read(3, 6);
    expect_val(16'hFFFF); check("fill_out", a_out);
    expect_val(16'hFFFF); check("fill_out_b", a_out_b);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    expect_val(16'h0000); check("rst_async_out", a_out);
    expect_val(16'h0000); check("rst_async_out_b", a_out_b);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_read(3'(k), 3'(7 - k));
      expect_val(16'h0000); check("after_rst", a_out);
    end

    // Load during reset is lost.
    @(negedge clk);
    rst = 1'b1; a_load = 1'b1; a_addr = 3'd1; a_in = 16'hFFFF;
    @(posedge clk); #1;
    expect_val(16'h0000); check("load_in_rst", a_out);
    @(negedge clk);
    rst = 1'b0; a_load = 1'b0;
    #1;
    expect_val(16'h0000); check("load_in_rst_after", a_out);

    // Write/readback, old data visible during the write cycle.
    @(negedge clk);
    a_load = 1'b1; a_addr = 3'd5; a_addr_b = 3'd5; a_in = 16'hBEEF;
    #1;
    expect_val(16'h0000); check("wr_cycle_out_b", a_out_b);
    expect_val(16'h0000); check("wr_cycle_out", a_out);
    @(posedge clk); #1;
    a_load = 1'b0;
    expect_val(16'hBEEF); check("wr_after_out_b", a_out_b);
    for (int k = 0; k < 8; k++) begin
      if (k != 5) begin
        a_read(3'(k), 3'(k));
        expect_val(16'h0000); check("wr_others", a_out_b);
      end
    end

    // Dual-port independence, hold over idle cycles, same-address reads.
    a_write(3'd2, 16'h1234);
    a_write(3'd7, 16'hA5A5);
    repeat (4) @(posedge clk);
    a_read(2, 7);
    expect_val(16'h1234); check("dp_out", a_out);
    expect_val(16'hA5A5); check("dp_out_b", a_out_b);
    a_addr = 3'd7; a_addr_b = 3'd2;
    #1;
    expect_val(16'hA5A5); check("dp_swap_out", a_out);
    expect_val(16'h1234); check("dp_swap_out_b", a_out_b);
    a_read(2, 2);
    expect_val(16'h1234); check("same_addr_out", a_out);
    expect_val(16'h1234); check("same_addr_out_b", a_out_b);

    // Clear beats a simultaneous load.
    for (int k = 0; k < 8; k++) a_write(3'(k), 16'(16'h1111 * (k + 1)));
    a_read(3, 4);
    expect_val(16'h4444); check("prefill_out", a_out);
    expect_val(16'h5555); check("prefill_out_b", a_out_b);
    @(negedge clk);
    a_clear = 1'b1; a_load = 1'b1; a_addr = 3'd3; a_in = 16'h5555;
    @(posedge clk); #1;
    a_clear = 1'b0; a_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_read(3'(k), 3'(k ^ 1));
      expect_val(16'h0000); check("clear_out", a_out);
      expect_val(16'h0000); check("clear_out_b", a_out_b);
    end

    // Bypass configuration.
    b_write(3'd4, 16'h0001);
    b_write(3'd1, 16'h0011);
    @(negedge clk);
    b_load = 1'b1; b_addr = 3'd4; b_addr_b = 3'd4; b_in = 16'h00FF;
    #1;
    expect_val(16'h00FF); check("byp_out", b_out);
    expect_val(16'h00FF); check("byp_out_b", b_out_b);
    @(posedge clk); #1;
    b_load = 1'b0;
    #1;
    expect_val(16'h00FF); check("byp_stored", b_out);
    @(negedge clk);
    b_load = 1'b1; b_addr = 3'd4; b_addr_b = 3'd1; b_in = 16'h0ABC;
    #1;
    expect_val(16'h0ABC); check("byp2_out", b_out);
    expect_val(16'h0011); check("byp2_out_b", b_out_b);
    @(posedge clk); #1;
    b_load = 1'b0;
    @(negedge clk);
    b_clear = 1'b1; b_load = 1'b1; b_addr = 3'd4; b_addr_b = 3'd4; b_in = 16'h1234;
    #1;
    expect_val(16'h0ABC); check("byp_clear_out", b_out);
    expect_val(16'h0ABC); check("byp_clear_out_b", b_out_b);
    @(posedge clk); #1;
    b_clear = 1'b0; b_load = 1'b0;
    #1;
    expect_val(16'h0000); check("byp_cleared", b_out);
    @(negedge clk);
    rst = 1'b1; b_load = 1'b1; b_in = 16'h7777;
    #1;
    expect_val(16'h0000); check("byp_in_rst", b_out);
    @(negedge clk);
    rst = 1'b0; b_load = 1'b0;

    // Wide-address configuration: word k holds k.
    for (int k = 0; k < 32; k++) c_write(5'(k), 8'(k));
    for (int k = 0; k < 32; k++) begin
      c_read(5'(k), 5'(31 - k));
      expect_val(16'(k));      check("param_out", {8'h00, c_out});
      expect_val(16'(31 - k)); check("param_out_b", {8'h00, c_out_b});
    end
    c_write(5'd31, 8'hEE);
    c_read(0, 31);
    expect_val(16'h0000); check("no_alias_w0", {8'h00, c_out});
    expect_val(16'h00EE); check("no_alias_w31", {8'h00, c_out_b});

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_array.md
Name: ram_array

Overview:
Parametrised word-addressable memory built as an array of load-enabled registers. It is the next step above the fixed 16-bit load register and replaces hand-instantiated register banks. Port A is a combined read/write port; port B is a second, read-only port. Adds asynchronous reset, a one-cycle bulk clear, and an optional write-through bypass.

Parameters:
- WIDTH, 16: bits per word.
- ADDR_W, 3: address width. DEPTH = 2**ADDR_W words, derived and not overridable.
- BYPASS, 0: 0 = reads return the stored value only; 1 = reads of the word being written return in combinationally.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset; clears every word.
- load, input, 1: write enable for port A.
- clear, input, 1: synchronous bulk clear of all words.
- address, input, ADDR_W: port A read/write address.
- in, input, WIDTH: port A write data.
- address_b, input, ADDR_W: port B read address.
- out, output, WIDTH: port A read data, combinational from address.
- out_b, output, WIDTH: port B read data, combinational from address_b.

Behaviour:
- Storage: DEPTH words of WIDTH bits. Every address value is legal; there is no out-of-range case.
- Reset: when rst rises, all words go to 0 immediately, independent of clk. While rst is high:
  - all words hold 0;
  - out and out_b read 0;
  - load and clear are ignored.
  - Deassertion takes effect with no extra cycle; the first edge after rst falls may write.
- Reset mid-operation: if rst is asserted in the same cycle as a load, the write is lost and the word stays 0.
- Write: on a rising clk edge with load=1, clear=0 and rst=0, mem[address] <= in. All other words hold. Latency is one edge: the new value is visible on out/out_b after that edge.
- Clear: on a rising clk edge with clear=1 and rst=0, all words <= 0. Clear has priority over load; a simultaneous load is discarded.
- Hold: with load=0 and clear=0, every word holds indefinitely.
- Read, BYPASS=0:
  - out = mem[address] and out_b = mem[address_b], purely combinational.
  - In the cycle of a write, both ports show the old contents.
- Read, BYPASS=1:
  - If load=1, clear=0, rst=0 and address==address_b, out_b = in.
  - Port A behaves the same way: out = in when load=1, clear=0 and rst=0.
  - If clear=1 in the same cycle, reads show the stored (pre-clear) data; there is no bypass of the clear.
- Same-address read on both ports is legal; both ports return the same value.
- There are no multicycle states. Behaviour is a per-word next-state mux (clear > load-select > hold) feeding DEPTH×WIDTH flops, plus two DEPTH:1 read muxes.

Test Plan:
1. Reset: WIDTH=16, ADDR_W=3; write 0xFFFF to all 8 words, then pulse rst between edges -> out=out_b=0x0000 immediately, before the next clk edge; all 8 words read 0 afterwards.
2. Write/readback: load=1, address=5, in=0xBEEF for one edge; address_b=5 -> out_b=0xBEEF after the edge, still 0x0000 during the write cycle (BYPASS=0); words 0-4, 6 and 7 remain 0.
3. Dual-port independence: mem[2]=0x1234 and mem[7]=0xA5A5; address=2, address_b=7 -> out=0x1234, out_b=0xA5A5; swap the addresses -> values swap with no clock edge.
4. Clear priority: with all words non-zero, assert clear=1 and load=1, address=3, in=0x5555 for one edge -> all words 0, including word 3.
5. Bypass: BYPASS=1, mem[4]=0x0001; load=1, address=4, address_b=4, in=0x00FF -> out=out_b=0x00FF before the edge; mem[4]=0x00FF after it. Repeat with address_b=1 -> out_b=mem[1] unchanged.
6. Parametrisation: WIDTH=8, ADDR_W=5; write address k with value k for all 32 words -> readback of every address on both ports equals its address; a write to 31 does not disturb word 0 (no wrap aliasing).
